// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: fixed-latency memory requests feeding a
// prefetch FIFO, with branch redirect and flush.
module instr_fetch_ctrl #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR = 16'h8000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fetch_en_i,
    input  logic                  branch_i,
    input  logic [ADDR_WIDTH-1:0] branch_addr_i,
    output logic                  instr_valid_o,
    output logic [DATA_WIDTH-1:0] instr_rdata_o,
    output logic [ADDR_WIDTH-1:0] instr_addr_o,
    input  logic                  instr_ready_i,
    output logic                  mem_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0]        DEPTH_L    = (CNT_W + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP    = ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(3));

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t                  state_r;
    logic [ADDR_WIDTH-1:0]   pc_r;
    logic                    inflight_r;
    logic [ADDR_WIDTH-1:0]   inflight_addr_r;
    logic [DATA_WIDTH-1:0]   fifo_data_r [DEPTH];
    logic [ADDR_WIDTH-1:0]   fifo_addr_r [DEPTH];
    logic [PTR_W-1:0]        wptr_r;
    logic [PTR_W-1:0]        rptr_r;
    logic [CNT_W-1:0]        count_r;

    logic [ADDR_WIDTH-1:0]   target_s;
    logic [CNT_W:0]          occupancy_s;
    logic                    credit_s;
    logic                    issue_s;
    logic                    push_s;
    logic                    pop_s;

    // Request issue, FIFO handshakes and head-of-queue outputs
    always_comb begin
        target_s    = branch_addr_i & ALIGN_MASK;
        occupancy_s = {1'b0, count_r} + {{CNT_W{1'b0}}, inflight_r};
        // A branch flushes both queued and returning words, so room is guaranteed
        if (branch_i) begin
            credit_s = 1'b1;
        end else begin
            credit_s = (occupancy_s < DEPTH_L);
        end
        issue_s  = fetch_en_i && ((state_r == FETCH) || branch_i) && credit_s;
        push_s   = inflight_r && !branch_i;
        pop_s    = (count_r != {CNT_W{1'b0}}) && instr_ready_i && !branch_i;
        mem_en_o = issue_s;
        if (!issue_s) begin
            mem_addr_o = {ADDR_WIDTH{1'b0}};
        end else if (branch_i) begin
            mem_addr_o = target_s;
        end else begin
            mem_addr_o = pc_r & ALIGN_MASK;
        end
        instr_valid_o = (count_r != {CNT_W{1'b0}});
        if (instr_valid_o) begin
            instr_rdata_o = fifo_data_r[rptr_r];
            instr_addr_o  = fifo_addr_r[rptr_r];
        end else begin
            instr_rdata_o = {DATA_WIDTH{1'b0}};
            instr_addr_o  = {ADDR_WIDTH{1'b0}};
        end
    end

    // Control FSM: requests are only generated while in FETCH
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            case (state_r)
                IDLE:    state_r <= fetch_en_i ? FETCH : IDLE;
                FETCH:   state_r <= fetch_en_i ? FETCH : IDLE;
                default: state_r <= IDLE;
            endcase
        end
    end

    // PC, in-flight tracking and FIFO pointers/occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r            <= BOOT_ADDR;
            inflight_r      <= 1'b0;
            inflight_addr_r <= {ADDR_WIDTH{1'b0}};
            wptr_r          <= {PTR_W{1'b0}};
            rptr_r          <= {PTR_W{1'b0}};
            count_r         <= {CNT_W{1'b0}};
        end else begin
            inflight_r      <= issue_s;
            inflight_addr_r <= mem_addr_o;
            if (branch_i) begin
                pc_r    <= issue_s ? (target_s + PC_STEP) : target_s;
                wptr_r  <= {PTR_W{1'b0}};
                rptr_r  <= {PTR_W{1'b0}};
                count_r <= {CNT_W{1'b0}};
            end else begin
                if (issue_s) begin
                    pc_r <= pc_r + PC_STEP;
                end
                if (push_s) begin
                    wptr_r <= wptr_r + PTR_W'(1);
                end
                if (pop_s) begin
                    rptr_r <= rptr_r + PTR_W'(1);
                end
                case ({push_s, pop_s})
                    2'b10:   count_r <= count_r + CNT_W'(1);
                    2'b01:   count_r <= count_r - CNT_W'(1);
                    default: count_r <= count_r;
                endcase
            end
        end
    end

    // FIFO storage; empty entries are masked at the output, so no reset needed
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_data_r[wptr_r] <= mem_rdata_i;
            fifo_addr_r[wptr_r] <= inflight_addr_r;
        end
    end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed self-checking bench for instr_fetch_ctrl with a one-cycle
// latency instruction memory model.
module tb_instr_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic        branch;
    logic [15:0] branch_addr;
    logic        instr_valid;
    logic [31:0] instr_rdata;
    logic [15:0] instr_addr;
    logic        instr_ready;
    logic        mem_en;
    logic [15:0] mem_addr;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;
    int issued;

    instr_fetch_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fetch_en_i    (fetch_en),
        .branch_i      (branch),
        .branch_addr_i (branch_addr),
        .instr_valid_o (instr_valid),
        .instr_rdata_o (instr_rdata),
        .instr_addr_o  (instr_addr),
        .instr_ready_i (instr_ready),
        .mem_en_o      (mem_en),
        .mem_addr_o    (mem_addr),
        .mem_rdata_i   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory returns a word tagged with its own address one cycle after the request
    always @(posedge clk) begin
        mem_rdata <= mem_en ? {16'hC0DE, mem_addr} : 32'h0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #3;
    endtask

    // Reset pulse, ending in the first post-reset cycle (FSM still IDLE)
    task automatic restart(input logic en, input logic rdy);
        rst_n       = 1'b0;
        branch      = 1'b0;
        fetch_en    = en;
        instr_ready = rdy;
        cyc();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; fetch_en = 1'b0; branch = 1'b0;
        branch_addr = 16'h0; instr_ready = 1'b0;
        repeat (2) cyc();
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        chk("rst_rdata", instr_rdata, 32'd0);
        chk("rst_iaddr", {16'd0, instr_addr}, 32'd0);

        // Boot fetch stream
        fetch_en = 1'b1; instr_ready = 1'b1; rst_n = 1'b1; #1;
        chk("boot_idle", {31'd0, mem_en}, 32'd0);
        cyc(); chk("boot_req0", {15'd0, mem_en, mem_addr}, 32'h0001_8000);
        cyc(); chk("boot_req1", {16'd0, mem_addr}, 32'h8004);
        chk("boot_novalid", {31'd0, instr_valid}, 32'd0);
        cyc(); chk("boot_req2", {16'd0, mem_addr}, 32'h8008);
        chk("boot_valid", {31'd0, instr_valid}, 32'd1);
        chk("boot_head", {16'd0, instr_addr}, 32'h8000);
        chk("boot_data", instr_rdata, 32'hC0DE_8000);
        cyc(); chk("boot_tput", {16'd0, instr_addr}, 32'h8004);

        // Backpressure fills the FIFO, then drains in order
        restart(1'b1, 1'b0);
        issued = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            if (mem_en) issued++;
        end
        chk("cap_reqs", issued, 32'd4);
        chk("cap_stall", {31'd0, mem_en}, 32'd0);
        instr_ready = 1'b1; #1;
        chk("drain0", {15'd0, mem_en, instr_addr}, 32'h0000_8000);
        cyc(); chk("drain1", {16'd0, instr_addr}, 32'h8004);
        chk("resume0", {15'd0, mem_en, mem_addr}, 32'h0001_8010);
        cyc(); chk("drain2", {16'd0, instr_addr}, 32'h8008);
        chk("resume1", {16'd0, mem_addr}, 32'h8014);
        cyc(); chk("drain3", {16'd0, instr_addr}, 32'h800C);
        cyc(); chk("drain4", {16'd0, instr_addr}, 32'h8010);

        // Branch with 3 queued and 1 in flight
        restart(1'b1, 1'b0);
        repeat (5) cyc();
        chk("pre_br_full", {15'd0, instr_valid, 15'd0, mem_en}, 32'h0001_0000);
        branch = 1'b1; branch_addr = 16'h0100; #1;
        chk("br_req", {15'd0, mem_en, mem_addr}, 32'h0001_0100);
        cyc(); branch = 1'b0; #1;
        chk("br_flush", {31'd0, instr_valid}, 32'd0);
        chk("br_req2", {16'd0, mem_addr}, 32'h0104);
        cyc(); chk("br_first", {15'd0, instr_valid, instr_addr}, 32'h0001_0100);
        chk("br_data", instr_rdata, 32'hC0DE_0100);
        instr_ready = 1'b1;
        cyc(); chk("br_second", {16'd0, instr_addr}, 32'h0104);

        // Branch coinciding with a pop
        restart(1'b1, 1'b1);
        repeat (3) cyc();
        branch = 1'b1; branch_addr = 16'h0200; #1;
        chk("brpop_req", {16'd0, mem_addr}, 32'h0200);
        cyc(); branch = 1'b0; #1;
        chk("brpop_empty", {31'd0, instr_valid}, 32'd0);
        cyc(); chk("brpop_first", {16'd0, instr_addr}, 32'h0200);
        cyc(); chk("brpop_second", {16'd0, instr_addr}, 32'h0204);

        // Unaligned branch near top of address space wraps
        branch = 1'b1; branch_addr = 16'hFFFE; #1;
        chk("wrap_req0", {16'd0, mem_addr}, 32'hFFFC);
        cyc(); branch = 1'b0; #1;
        chk("wrap_req1", {15'd0, mem_en, mem_addr}, 32'h0001_0000);
        cyc(); chk("wrap_head0", {16'd0, instr_addr}, 32'hFFFC);
        cyc(); chk("wrap_head1", {15'd0, instr_valid, instr_addr}, 32'h0001_0000);

        // fetch_en drop with a request in flight, then resume
        restart(1'b1, 1'b0);
        cyc(); chk("pause_req", {16'd0, mem_addr}, 32'h8000);
        cyc(); fetch_en = 1'b0; #1;
        chk("pause_noreq", {31'd0, mem_en}, 32'd0);
        cyc(); chk("pause_capt", {15'd0, instr_valid, instr_addr}, 32'h0001_8000);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("pause_hold", {15'd0, instr_valid, 15'd0, mem_en}, 32'h0001_0000);
        end
        fetch_en = 1'b1; #1;
        chk("resume_idle", {31'd0, mem_en}, 32'd0);
        cyc(); chk("resume_seq", {15'd0, mem_en, mem_addr}, 32'h0001_8004);

        // Branch while disabled: flush and retarget only
        cyc(); fetch_en = 1'b0; branch = 1'b1; branch_addr = 16'h0401; #1;
        chk("brdis_noreq", {31'd0, mem_en}, 32'd0);
        cyc(); branch = 1'b0; fetch_en = 1'b1; #1;
        chk("brdis_flush", {15'd0, instr_valid, 15'd0, mem_en}, 32'd0);
        cyc(); chk("brdis_req", {15'd0, mem_en, mem_addr}, 32'h0001_0400);
        cyc(); chk("brdis_req2", {16'd0, mem_addr}, 32'h0404);
        cyc(); chk("brdis_head", {15'd0, instr_valid, instr_addr}, 32'h0001_0400);

        // Mid-operation reset discards queued and in-flight words
        rst_n = 1'b0; #1;
        chk("mrst_valid", {15'd0, instr_valid, instr_addr}, 32'd0);
        chk("mrst_mem", {15'd0, mem_en, mem_addr}, 32'd0);
        cyc(); rst_n = 1'b1; instr_ready = 1'b1; #1;
        cyc(); cyc();
        chk("mrst_nostale", {31'd0, instr_valid}, 32'd0);
        cyc(); chk("mrst_first", {15'd0, instr_valid, instr_addr}, 32'h0001_8000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
